// File: rtl/bocks_ioctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bocks_ioctl_pkg
// Description : Shared types for the ioctl-to-SDRAM loader: FSM state encoding,
//               the default FIFO entry layout and a byte-lane helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bocks_ioctl_pkg;

  localparam int unsigned ADDR_W_DEF     = 25;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  // Encoding is visible on the state output, so values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ioctl_state_e;

  // Word write at the default address width.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [15:0]           data;
    logic [1:0]            be;
  } fifo_entry_t;

  // Byte enable for a single byte: even address -> low lane, odd -> high lane.
  function automatic logic [1:0] lane_be(input logic odd);
    return odd ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ioctl_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_word_fifo
// Description : Small synchronous FIFO of packed word-write entries.
//               Simultaneous push and pop keeps the count unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_word_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W:0]   count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rptr_q];
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Storage array; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) wptr_q <= wptr_q + 1'b1;
      if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ioctl_sdram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_sdram_loader
// Description : Packs the HPS ioctl byte stream into 16-bit SDRAM word writes
//               with byte enables, buffers them and issues them over a
//               valid/ack channel, throttling the HPS with ioctl_wait.
//               Optional feature macro: IOCTL_CHECKSUM_EN (byte checksum).
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_sdram_loader
  import bocks_ioctl_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [7:0]        INDEX_MATCH = 8'h00,
  parameter int unsigned       FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic              ch_req,
  output logic [ADDR_W-1:0] ch_addr,
  output logic [15:0]       ch_din,
  output logic [1:0]        ch_be,
  input  logic              ch_ack,
  output logic              done,
  output logic [2:0]        state,
  output logic [15:0]       checksum
);

  localparam int unsigned ENTRY_W = ADDR_W + 18;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } entry_t;

  ioctl_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [15:0]       pend_data_q, pend_data_d;
  logic [1:0]        pend_be_q, pend_be_d;

  logic              w_push;
  entry_t            w_push_entry;
  entry_t            w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_fifo_full_unused;

  logic              w_accept;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_lane;
  logic              w_evict;
  logic              w_fresh;
  logic [15:0]       w_base_data;
  logic [1:0]        w_base_be;
  logic [15:0]       w_new_data;
  logic [1:0]        w_new_be;

  // Address bits above ADDR_W carry no meaning for this SDRAM.
  if (ADDR_W < 27) begin : g_addr_hi
    logic w_addr_hi_unused;
    assign w_addr_hi_unused = ^ioctl_addr[26:ADDR_W];
  end

  assign ioctl_wait = (w_count >= CNT_W'(FIFO_DEPTH - 1)) ||
                      (state_q == ST_FLUSH) || (state_q == ST_DRAIN) ||
                      (state_q == ST_DONE);
  assign w_accept   = (state_q == ST_LOAD) && ioctl_wr && ioctl_download && !ioctl_wait;

  // Byte merge: a new word address evicts the pending partial word first.
  assign w_word_addr = BASE_ADDR + {ioctl_addr[ADDR_W-1:1], 1'b0};
  assign w_lane      = ioctl_addr[0];
  assign w_evict     = (pend_be_q != 2'b00) && (w_word_addr != pend_addr_q);
  assign w_fresh     = (pend_be_q == 2'b00) || w_evict;
  assign w_base_data = w_fresh ? 16'h0000 : pend_data_q;
  assign w_base_be   = w_fresh ? 2'b00 : pend_be_q;
  assign w_new_data  = w_lane ? {ioctl_dout, w_base_data[7:0]} : {w_base_data[15:8], ioctl_dout};
  assign w_new_be    = w_base_be | lane_be(w_lane);

  // Next-state, pending-word update and FIFO push selection.
  always_comb begin
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_be_d    = pend_be_q;
    w_push       = 1'b0;
    w_push_entry = '{addr: pend_addr_q, data: pend_data_q, be: pend_be_q};
    case (state_q)
      ST_IDLE: begin
        if (ioctl_download && (ioctl_index == INDEX_MATCH)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_d = ST_FLUSH;
        end else if (w_accept) begin
          // Eviction leaves a single-lane word, so at most one push per cycle.
          if (w_evict) w_push = 1'b1;
          if (w_new_be == 2'b11) begin
            w_push       = 1'b1;
            w_push_entry = '{addr: w_word_addr, data: w_new_data, be: w_new_be};
            pend_be_d    = 2'b00;
            pend_data_d  = 16'h0000;
          end else begin
            pend_addr_d = w_word_addr;
            pend_data_d = w_new_data;
            pend_be_d   = w_new_be;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_DRAIN;
        if (pend_be_q != 2'b00) begin
          w_push      = 1'b1;
          pend_be_d   = 2'b00;
          pend_data_d = 16'h0000;
        end
      end
      ST_DRAIN: begin
        if (w_empty) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and pending-word registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_be_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_be_q   <= pend_be_d;
    end
  end

  ioctl_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .push_i  (w_push),
    .wdata_i (w_push_entry),
    .pop_i   (ch_ack),
    .rdata_o (w_head),
    .count_o (w_count),
    .empty_o (w_empty),
    .full_o  (w_fifo_full_unused)
  );

  // Head is masked while empty so the channel idles at zero.
  assign ch_req  = !w_empty;
  assign ch_addr = w_empty ? '0 : w_head.addr;
  assign ch_din  = w_empty ? '0 : w_head.data;
  assign ch_be   = w_empty ? '0 : w_head.be;
  assign done    = (state_q == ST_DONE);
  assign state   = state_q;

`ifdef IOCTL_CHECKSUM_EN
  logic [15:0] csum_q;

  // Running sum of accepted bytes, restarted when a download begins.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
      csum_q <= '0;
    end else if (w_accept) begin
      csum_q <= csum_q + {8'h00, ioctl_dout};
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ioctl_sdram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioctl_sdram_loader
// Description : Self-checking bench for ioctl_sdram_loader: directed vector
//               table, hand-written corner sequences and randomized downloads
//               against a byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_sdram_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic        ch_req;
  logic [24:0] ch_addr;
  logic [15:0] ch_din;
  logic [1:0]  ch_be;
  logic        ch_ack = 1'b0;
  logic        done;
  logic [2:0]  state;
  logic [15:0] checksum;

  ioctl_sdram_loader #(
    .ADDR_W      (25),
    .BASE_ADDR   (25'h0),
    .INDEX_MATCH (8'h00),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .ch_req         (ch_req),
    .ch_addr        (ch_addr),
    .ch_din         (ch_din),
    .ch_be          (ch_be),
    .ch_ack         (ch_ack),
    .done           (done),
    .state          (state),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  typedef logic [42:0] wr_t;  // {addr[24:0], data[15:0], be[1:0]}

  typedef struct packed {
    logic [2:0]        n;
    logic [3:0][26:0]  a;
    logic [3:0][7:0]   d;
    logic [1:0]        ne;
    logic [2:0][42:0]  e;
  } vec_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [2:0]  trace_q[$];
  logic [2:0]  last_state = 3'd0;
  logic [26:0] b_addr[$];
  logic [7:0]  b_data[$];
  int          done_cnt = 0;
  int          ack_mode = 0;   // 0 always ack, 1 never, 2 random
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_csum(input logic [15:0] s);
`ifdef IOCTL_CHECKSUM_EN
    return s;
`else
    return 16'h0000 & s;
`endif
  endfunction

  // Channel responder and observer: ack decision, write capture, state trace.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      ch_ack     = 1'b0;
      last_state = 3'd0;
    end else begin
      if (state != last_state) begin
        trace_q.push_back(state);
        last_state = state;
      end
      if (done) done_cnt++;
      case (ack_mode)
        0:       ch_ack = 1'b1;
        1:       ch_ack = 1'b0;
        default: ch_ack = 1'($urandom_range(0, 1));
      endcase
      if (ch_req && ch_ack) got_q.push_back({ch_addr, ch_din, ch_be});
    end
  end

  // Expected word writes from the byte stream: bytes group into words by
  // word address; a word goes out when complete, when the stream moves to a
  // different word, or at end of download.
  task automatic build_expected(output logic [15:0] sum);
    logic [24:0] pa, wa;
    logic [15:0] pd;
    logic [1:0]  pb;
    exp_q.delete();
    pa = '0; pd = '0; pb = '0; sum = '0;
    for (int i = 0; i < b_addr.size(); i++) begin
      wa  = 25'((b_addr[i] % 27'h2000000) / 2 * 2);
      sum = sum + 16'(b_data[i]);
      if (pb != 2'b00 && wa != pa) begin
        exp_q.push_back({pa, pd, pb});
        pb = 2'b00;
      end
      if (pb == 2'b00) begin
        pa = wa;
        pd = '0;
      end
      if (b_addr[i] % 2 == 1) begin
        pd[15:8] = b_data[i];
        pb[1]    = 1'b1;
      end else begin
        pd[7:0]  = b_data[i];
        pb[0]    = 1'b1;
      end
      if (pb == 2'b11) begin
        exp_q.push_back({pa, pd, pb});
        pb = 2'b00;
      end
    end
    if (pb != 2'b00) exp_q.push_back({pa, pd, pb});
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    int n;
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    n = 0;
    while (ioctl_wait && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 500) check("wait_timeout", 64'(ioctl_wait), 64'd0);
    @(posedge clk_sys);
    #1 ioctl_wr = 1'b0;
  endtask

  task automatic wait_done();
    int n, d0;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check("done_seen", 64'(done_cnt != d0), 64'd1);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic download(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_download = 1'b1;
    for (int i = 0; i < b_addr.size(); i++) send_byte(b_addr[i], b_data[i]);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    wait_done();
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++)
      if (j < got_q.size()) check({tag, "_wr"}, 64'(got_q[j]), 64'(exp_q[j]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [2:0]  st_exp[5];
    logic [15:0] sum;
    logic [26:0] a;
    int          nb, r, n;

    st_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    vecs[0] = '{n: 3'd4, a: {27'd3, 27'd2, 27'd1, 27'd0}, d: {8'h44, 8'h33, 8'h22, 8'h11},
                ne: 2'd2, e: {43'd0, {25'd2, 16'h4433, 2'b11}, {25'd0, 16'h2211, 2'b11}}};
    vecs[1] = '{n: 3'd3, a: {27'd0, 27'd2, 27'd1, 27'd0}, d: {8'h00, 8'hCC, 8'hBB, 8'hAA},
                ne: 2'd2, e: {43'd0, {25'd2, 16'h00CC, 2'b01}, {25'd0, 16'hBBAA, 2'b11}}};
    vecs[2] = '{n: 3'd2, a: {27'd0, 27'd0, 27'd8, 27'd5}, d: {8'h00, 8'h00, 8'h66, 8'h55},
                ne: 2'd2, e: {43'd0, {25'd8, 16'h0066, 2'b01}, {25'd4, 16'h5500, 2'b10}}};
    vecs[3] = '{n: 3'd3, a: {27'd0, 27'd1, 27'd0, 27'd0}, d: {8'h00, 8'h22, 8'h99, 8'h11},
                ne: 2'd1, e: {43'd0, 43'd0, {25'd0, 16'h2299, 2'b11}}};
    vecs[4] = '{n: 3'd3, a: {27'd0, 27'd3, 27'd0, 27'd1}, d: {8'h00, 8'h77, 8'h11, 8'h22},
                ne: 2'd2, e: {43'd0, {25'd2, 16'h7700, 2'b10}, {25'd0, 16'h2211, 2'b11}}};
    vecs[5] = '{n: 3'd3, a: {27'd0, 27'h1FFFFFF, 27'h6000005, 27'h6000004},
                d: {8'h00, 8'h3C, 8'hA5, 8'h5A},
                ne: 2'd2, e: {43'd0, {25'h1FFFFFE, 16'h3C00, 2'b10}, {25'd4, 16'hA55A, 2'b11}}};

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_req",   64'(ch_req), 64'd0);
    check("rst_wait",  64'(ioctl_wait), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_addr",  64'(ch_addr), 64'd0);
    check("rst_din",   64'(ch_din), 64'd0);
    check("rst_be",    64'(ch_be), 64'd0);
    check("rst_csum",  64'(checksum), 64'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      b_addr.delete(); b_data.delete();
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        b_addr.push_back(vecs[i].a[k]);
        b_data.push_back(vecs[i].d[k]);
      end
      got_q.delete(); trace_q.delete();
      ack_mode = (i % 3 == 1) ? 2 : 0;
      download(8'h00);
      check("vec_nwr", 64'(got_q.size()), 64'(vecs[i].ne));
      for (int j = 0; j < int'(vecs[i].ne); j++)
        if (j < got_q.size()) check("vec_wr", 64'(got_q[j]), 64'(vecs[i].e[j]));
      check("vec_ntrace", 64'(trace_q.size()), 64'd5);
      for (int j = 0; j < 5; j++)
        if (j < trace_q.size()) check("vec_state", 64'(trace_q[j]), 64'(st_exp[j]));
    end

    // Latency: odd byte accepted at N gives ch_req at N+1
    got_q.delete();
    ack_mode = 1;
    @(negedge clk_sys);
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    send_byte(27'd0, 8'hAA);
    check("lat_req_even", 64'(ch_req), 64'd0);
    send_byte(27'd1, 8'hBB);
    check("lat_req_odd", 64'(ch_req), 64'd1);
    check("lat_head", 64'({ch_addr, ch_din, ch_be}), 64'({25'd0, 16'hBBAA, 2'b11}));
    ack_mode = 0;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    wait_done();
    check("lat_nwr", 64'(got_q.size()), 64'd1);

    // Backpressure: no acks while streaming 12 bytes
    got_q.delete();
    b_addr.delete(); b_data.delete();
    for (int k = 0; k < 12; k++) begin
      b_addr.push_back(27'(k));
      b_data.push_back(8'(8'h10 + k));
    end
    build_expected(sum);
    ack_mode = 1;
    @(negedge clk_sys);
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send_byte(b_addr[k], b_data[k]);
      if (k == 3) check("bp_wait_low", 64'(ioctl_wait), 64'd0);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = b_addr[6]; ioctl_dout = b_data[6];
    for (int k = 0; k < 4; k++) begin
      check("bp_wait_high", 64'(ioctl_wait), 64'd1);
      @(negedge clk_sys);
    end
    check("bp_nothing_sent", 64'(got_q.size()), 64'd0);
    ack_mode = 2;
    for (int k = 6; k < 12; k++) send_byte(b_addr[k], b_data[k]);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    wait_done();
    compare_writes("bp");
    check("bp_csum", 64'(checksum), 64'(exp_csum(sum)));

    // Checksum of FF,FF,02
    got_q.delete();
    b_addr.delete(); b_data.delete();
    b_addr = '{27'd0, 27'd1, 27'd2};
    b_data = '{8'hFF, 8'hFF, 8'h02};
    ack_mode = 0;
    download(8'h00);
`ifdef IOCTL_CHECKSUM_EN
    check("csum_ff", 64'(checksum), 64'h0200);
`else
    check("csum_off", 64'(checksum), 64'h0000);
`endif

    // Index mismatch: download ignored
    got_q.delete();
    @(negedge clk_sys);
    ioctl_index = 8'h01; ioctl_download = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 27'd1; ioctl_dout = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      check("idx_state", 64'(state), 64'd0);
      check("idx_req", 64'(ch_req), 64'd0);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
    repeat (2) @(negedge clk_sys);

    // Asynchronous reset during DRAIN
    ack_mode = 1;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    for (int k = 0; k < 4; k++) send_byte(27'(k), 8'(8'hC0 + k));
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    n = 0;
    while (state != 3'd3 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("drain_reached", 64'(state), 64'd3);
    check("drain_req", 64'(ch_req), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_req",   64'(ch_req), 64'd0);
    check("arst_state", 64'(state), 64'd0);
    check("arst_wait",  64'(ioctl_wait), 64'd0);
    check("arst_head",  64'({ch_addr, ch_din, ch_be}), 64'd0);
    check("arst_done",  64'(done), 64'd0);
    check("arst_csum",  64'(checksum), 64'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    ack_mode = 0;
    repeat (2) @(negedge clk_sys);

    // Randomized downloads against the reference model
    for (int t = 0; t < 8; t++) begin
      b_addr.delete(); b_data.delete();
      a  = (t == 7) ? 27'h7FFFFF0 : 27'($urandom_range(0, 100));
      nb = $urandom_range(3, 20);
      for (int k = 0; k < nb; k++) begin
        b_addr.push_back(a);
        b_data.push_back(8'($urandom));
        r = $urandom_range(0, 9);
        if (r < 7)                 a = a + 27'd1;
        else if (r == 8)           a = a + 27'($urandom_range(2, 5));
        else if (r == 9 && a != 0) a = a - 27'd1;
      end
      ack_mode = (t % 2 == 0) ? 2 : 0;
      got_q.delete(); trace_q.delete();
      build_expected(sum);
      download(8'h00);
      compare_writes("rand");
      check("rand_csum", 64'(checksum), 64'(exp_csum(sum)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
